// File: rtl/regfile_write_arbiter_if.sv
// Bundles the writeback-requester handshake and the RegisterFile write port.
// The arbiter uses the slave modport; the surrounding logic uses the master modport.
interface regfile_write_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 18
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   stall;
    logic [ADDR_W-1:0]      write_addr;
    logic [DATA_W-1:0]      write_data;
    logic                   write_enable;
    logic [2:0]             grant_id;
    logic [2**ADDR_W-1:0]   busy_mask;
    logic [15:0]            write_count;

    modport master (
        output req_valid, req_addr, req_data, stall,
        input  req_ready, write_addr, write_data, write_enable,
               grant_id, busy_mask, write_count
    );

    modport slave (
        input  req_valid, req_addr, req_data, stall,
        output req_ready, write_addr, write_data, write_enable,
               grant_id, busy_mask, write_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single RegisterFile write port among NREQ
// writeback requesters; the port is driven from registers one cycle after the handshake.
module regfile_write_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 18
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    regfile_write_arbiter_if.slave bus
);
    localparam int NREG  = 2 ** ADDR_W;
    localparam int GID_W = 3;

    function automatic logic [NREG-1:0] reg_onehot(input logic [ADDR_W-1:0] addr);
        reg_onehot = {{(NREG-1){1'b0}}, 1'b1} << addr;
    endfunction

    logic [GID_W-1:0]  r_rr_ptr;
    logic [ADDR_W-1:0] r_write_addr;
    logic [DATA_W-1:0] r_write_data;
    logic              r_write_enable;
    logic [GID_W-1:0]  r_grant_id;
    logic [15:0]       r_write_count;

    logic [7:0]        w_valid_ext;
    logic [GID_W:0]    w_sum;
    logic [GID_W-1:0]  w_idx;
    logic              w_hit;
    logic              w_found;
    logic [GID_W-1:0]  w_winner;
    logic              w_grant;
    logic [NREQ-1:0]   w_ready;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic [GID_W-1:0]  w_next_ptr;
    logic [15:0]       w_count_next;
    logic [NREG-1:0]   w_busy;

    // Widened so the search index never exceeds the vector range for any NREQ.
    assign w_valid_ext = 8'(bus.req_valid);

    // Round-robin search: first valid requester at or above r_rr_ptr, wrapping modulo NREQ.
    always_comb begin
        w_sum    = {(GID_W+1){1'b0}};
        w_idx    = {GID_W{1'b0}};
        w_hit    = 1'b0;
        w_found  = 1'b0;
        w_winner = {GID_W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            w_sum    = {1'b0, r_rr_ptr} + 4'(k);
            w_idx    = (w_sum >= 4'(NREQ)) ? 3'(w_sum - 4'(NREQ)) : w_sum[GID_W-1:0];
            w_hit    = w_valid_ext[w_idx] && !w_found;
            w_winner = w_hit ? w_idx : w_winner;
            w_found  = w_found || w_hit;
        end
    end

    // Reset and stall both veto the grant; ready is one-hot on the winner only.
    always_comb begin
        w_grant = w_found && !i_rst && !bus.stall;
        w_ready = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            w_ready[i] = w_grant && (w_winner == GID_W'(i));
        end
    end

    // Mux the winner's address and data onto the capture path.
    always_comb begin
        w_sel_addr = {ADDR_W{1'b0}};
        w_sel_data = {DATA_W{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            w_sel_addr = (w_winner == GID_W'(i)) ? bus.req_addr[i*ADDR_W +: ADDR_W] : w_sel_addr;
            w_sel_data = (w_winner == GID_W'(i)) ? bus.req_data[i*DATA_W +: DATA_W] : w_sel_data;
        end
    end

    // Pointer advance past the winner and saturating write counter.
    always_comb begin
        w_next_ptr   = (w_winner == GID_W'(NREQ - 1)) ? 3'd0 : (w_winner + 3'd1);
        w_count_next = (r_write_count == 16'hFFFF) ? r_write_count : (r_write_count + 16'd1);
    end

    // Busy: every pending request target plus the register currently on the port.
    always_comb begin
        w_busy = r_write_enable ? reg_onehot(r_write_addr) : {NREG{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            w_busy = bus.req_valid[i] ? (w_busy | reg_onehot(bus.req_addr[i*ADDR_W +: ADDR_W]))
                                      : w_busy;
        end
    end

    // Port registers: load on a transfer, otherwise drop enable and hold the fields.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr       <= 3'd0;
            r_write_addr   <= {ADDR_W{1'b0}};
            r_write_data   <= {DATA_W{1'b0}};
            r_write_enable <= 1'b0;
            r_grant_id     <= 3'd0;
            r_write_count  <= 16'd0;
        end else if (w_grant) begin
            r_rr_ptr       <= w_next_ptr;
            r_write_addr   <= w_sel_addr;
            r_write_data   <= w_sel_data;
            r_write_enable <= 1'b1;
            r_grant_id     <= w_winner;
            r_write_count  <= w_count_next;
        end else begin
            r_write_enable <= 1'b0;
        end
    end

    assign bus.req_ready    = w_ready;
    assign bus.write_addr   = r_write_addr;
    assign bus.write_data   = r_write_data;
    assign bus.write_enable = r_write_enable;
    assign bus.grant_id     = r_grant_id;
    assign bus.busy_mask    = w_busy;
    assign bus.write_count  = r_write_count;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: requester FIFOs feed the DUT, a
// reference model predicts grants and port contents, and a monitor checks the port.
module tb_regfile_write_arbiter;
    localparam int NREQ   = 3;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 18;
    localparam int DEPTH  = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_write_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  a;
        logic [17:0] d;
        logic [2:0]  g;
    } sb_t;

    logic [21:0] rbuf [NREQ][DEPTH];
    int          rhead [NREQ];
    int          rtail [NREQ];

    sb_t         sbq [$];
    logic [17:0] rf [16];
    logic [17:0] exp_regs [16];
    bit          exp_known [16];

    int  m_ptr, m_count, m_gid;
    bit  m_port_v, m_rst_prev;
    int  m_port_a;
    int  checks = 0;
    int  errors = 0;

    // RegisterFile model written straight from the DUT write port.
    always @(posedge clk) begin
        if (bus.write_enable) rf[bus.write_addr] <= bus.write_data;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rsize(input int i);
        return rtail[i] - rhead[i];
    endfunction

    task automatic push_req(input int i, input logic [3:0] a, input logic [17:0] d);
        rbuf[i][rtail[i] % DEPTH] = {a, d};
        rtail[i]++;
    endtask

    // One cycle: drive inputs, check against the model, then advance the model.
    task automatic step(input bit r, input bit s);
        logic [21:0] item;
        logic [15:0] exp_busy;
        logic [2:0]  exp_ready;
        bit          v [NREQ];
        int          win;
        int          idx;
        @(negedge clk);
        rst = r;
        bus.stall = s;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = rsize(i) > 0;
            bus.req_valid[i] = v[i];
            if (v[i]) begin
                item = rbuf[i][rhead[i] % DEPTH];
                bus.req_addr[i*ADDR_W +: ADDR_W] = item[21:18];
                bus.req_data[i*DATA_W +: DATA_W] = item[17:0];
            end else begin
                bus.req_addr[i*ADDR_W +: ADDR_W] = 4'($urandom);
                bus.req_data[i*DATA_W +: DATA_W] = 18'($urandom);
            end
        end
        #1;
        exp_busy = m_port_v ? (16'h1 << m_port_a) : 16'h0;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) exp_busy |= 16'h1 << bus.req_addr[i*ADDR_W +: ADDR_W];
        end
        win = -1;
        if (!r && !s) begin
            for (int j = 0; j < NREQ; j++) begin
                idx = (m_ptr + j) % NREQ;
                if (win < 0 && v[idx]) win = idx;
            end
        end
        exp_ready = (win >= 0) ? (3'b001 << win) : 3'b000;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        chk("busy_mask", 64'(bus.busy_mask), 64'(exp_busy));
        chk("write_count", 64'(bus.write_count), 64'(m_count));
        chk("write_enable", 64'(bus.write_enable), 64'(m_port_v));
        chk("grant_id", 64'(bus.grant_id), 64'(m_gid));
        if (m_rst_prev) begin
            chk("reset_addr", 64'(bus.write_addr), 64'd0);
            chk("reset_data", 64'(bus.write_data), 64'd0);
        end
        m_rst_prev = r;
        if (r) begin
            m_ptr = 0; m_count = 0; m_port_v = 0; m_gid = 0;
        end else if (win >= 0) begin
            item = rbuf[win][rhead[win] % DEPTH];
            rhead[win]++;
            sbq.push_back('{a: item[21:18], d: item[17:0], g: 3'(win)});
            exp_regs[item[21:18]] = item[17:0];
            exp_known[item[21:18]] = 1'b1;
            m_ptr = (win + 1) % NREQ;
            m_count = (m_count >= 65535) ? 65535 : m_count + 1;
            m_port_v = 1;
            m_port_a = int'(item[21:18]);
            m_gid = win;
        end else begin
            m_port_v = 0;
        end
    endtask

    // Monitor: every enabled write must match the oldest expected transfer.
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #1;
            chk("sb_wen", 64'(bus.write_enable), 64'(sbq.size() != 0));
            if (bus.write_enable && sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("port_addr", 64'(bus.write_addr), 64'(e.a));
                chk("port_data", 64'(bus.write_data), 64'(e.d));
                chk("port_gid", 64'(bus.grant_id), 64'(e.g));
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.req_valid = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        for (int a = 0; a < 16; a++) exp_known[a] = 1'b0;
        m_ptr = 0; m_count = 0; m_gid = 0; m_port_v = 0; m_port_a = 0; m_rst_prev = 1;

        step(1, 0); step(1, 0); step(0, 0);

        // single requester
        push_req(0, 4'd3, 18'd42);
        repeat (3) step(0, 0);

        // round-robin, restarted from requester 0
        step(1, 0);
        for (int n = 0; n < 2; n++) begin
            push_req(0, 4'd1, 18'h000A5);
            push_req(1, 4'd2, 18'h00011);
            push_req(2, 4'd5, 18'h3FFFF);
        end
        repeat (8) step(0, 0);

        // same-address collision with pointer at 1
        push_req(0, 4'd9, 18'd1);
        step(0, 0);
        push_req(1, 4'd7, 18'd10);
        push_req(2, 4'd7, 18'd20);
        repeat (4) step(0, 0);

        // stall
        push_req(2, 4'd6, 18'd123);
        repeat (3) step(0, 1);
        repeat (3) step(0, 0);

        // reset while a write to register 4 is on the port
        push_req(1, 4'd4, 18'h01234);
        step(0, 0);
        push_req(0, 4'd8, 18'd55);
        push_req(2, 4'd9, 18'd66);
        step(1, 0);
        repeat (4) step(0, 0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 2) == 0 && rsize(i) < 4)
                    push_req(i, 4'($urandom), 18'($urandom));
            end
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0));
        end
        repeat (8) step(0, 0);

        // saturation of the write counter
        step(1, 0);
        for (int n = 0; n < 65540; n++) begin
            if (rsize(0) < 2) push_req(0, 4'($urandom), 18'($urandom));
            step(0, 0);
        end
        repeat (4) step(0, 0);
        chk("count_saturated", 64'(bus.write_count), 64'hFFFF);

        for (int a = 0; a < 16; a++) begin
            if (exp_known[a]) chk("regfile", 64'(rf[a]), 64'(exp_regs[a]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
